// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: default address width and Gray/binary conversions,
// used by both the read-side and write-side pointer logic.
package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH = 3;
  localparam int PTR_W_MAX       = 16;

  function automatic logic [PTR_W_MAX-1:0] bin2gray(input logic [PTR_W_MAX-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero-extended inputs convert correctly: the extra high Gray bits are 0.
  function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] gray);
    logic [PTR_W_MAX-1:0] bin;
    bin[PTR_W_MAX-1] = gray[PTR_W_MAX-1];
    for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/rptr_empty_if.sv
// Read-client bundle of the async FIFO read side: request, synchronized write
// pointer in; address, Gray pointer, flags and level out.
interface rptr_empty_if #(
  parameter int ADDR_WIDTH = fifo_pkg::FIFO_ADDR_WIDTH
);
  logic                  rinc;
  logic [ADDR_WIDTH:0]   rq2_wptr;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [ADDR_WIDTH:0]   rptr;
  logic                  rempty;
  logic                  raempty;
  logic [ADDR_WIDTH:0]   rlevel;
  logic                  runderflow;

  modport master (
    output rinc, rq2_wptr,
    input  raddr, rptr, rempty, raempty, rlevel, runderflow
  );

  modport slave (
    input  rinc, rq2_wptr,
    output raddr, rptr, rempty, raempty, rlevel, runderflow
  );
endinterface

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter of configurable width.
module gray2bin #(
  parameter int WIDTH = fifo_pkg::FIFO_ADDR_WIDTH + 1
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);
  localparam int PW = fifo_pkg::PTR_W_MAX;

  assign bin_o = WIDTH'(fifo_pkg::gray2bin(PW'(gray_i)));
endmodule

// File: rtl/rptr_empty.sv
// Async FIFO read pointer and registered empty flag. Define RPTR_EMPTY_LEVEL_EN
// to add the fill level and a level-based almost-empty flag.
module rptr_empty
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH    = FIFO_ADDR_WIDTH,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic         rclk,
  input  logic         rrst_n,
  rptr_empty_if.slave  rif
);
  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          rempty_q, rempty_d;
  logic          runderflow_q, runderflow_d;
  logic          rd_ok;

`ifdef RPTR_EMPTY_LEVEL_EN
  localparam logic [PW-1:0] THRESH = PW'(AEMPTY_THRESH);
  logic [PW-1:0] wbin_s;
  logic [PW-1:0] rlevel_q, rlevel_d;
  logic          raempty_q, raempty_d;

  gray2bin #(.WIDTH(PW)) u_gray2bin (
    .gray_i (rif.rq2_wptr),
    .bin_o  (wbin_s)
  );
`endif

  // NOTE: every always_comb output gets a value on every path, so no latches.
  always_comb begin
    rd_ok        = rif.rinc & ~rempty_q;
    rbin_d       = rbin_q + PW'(rd_ok);
    rptr_d       = PW'(bin2gray(PTR_W_MAX'(rbin_d)));
    // Full Gray compare including the wrap bit: equal means nothing left.
    rempty_d     = (rptr_d == rif.rq2_wptr);
    runderflow_d = runderflow_q | (rif.rinc & rempty_q);
`ifdef RPTR_EMPTY_LEVEL_EN
    rlevel_d     = wbin_s - rbin_d;
    raempty_d    = (rlevel_d <= THRESH);
`endif
  end

  // NOTE: reset is sampled on the clock edge; state uses non-blocking updates.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rbin_q       <= '0;
      rptr_q       <= '0;
      rempty_q     <= 1'b1;
      runderflow_q <= 1'b0;
`ifdef RPTR_EMPTY_LEVEL_EN
      rlevel_q     <= '0;
      raempty_q    <= 1'b1;
`endif
    end else begin
      rbin_q       <= rbin_d;
      rptr_q       <= rptr_d;
      rempty_q     <= rempty_d;
      runderflow_q <= runderflow_d;
`ifdef RPTR_EMPTY_LEVEL_EN
      rlevel_q     <= rlevel_d;
      raempty_q    <= raempty_d;
`endif
    end
  end

  assign rif.raddr      = rbin_q[ADDR_WIDTH-1:0];
  assign rif.rptr       = rptr_q;
  assign rif.rempty     = rempty_q;
  assign rif.runderflow = runderflow_q;
`ifdef RPTR_EMPTY_LEVEL_EN
  assign rif.rlevel     = rlevel_q;
  assign rif.raempty    = raempty_q;
`else
  assign rif.rlevel     = '0;
  assign rif.raempty    = rempty_q;
`endif
endmodule

// File: doc/rptr_empty.md
# rptr_empty

Read-side pointer and empty-flag generator for the asynchronous FIFO, the read-domain counterpart of the write-pointer/full logic. It holds the binary read pointer that addresses RAM and the Gray read pointer exported to the write-domain synchronizer. It compares that Gray pointer against the already-synchronized write pointer to produce a registered, pessimistic empty flag. It also reports fill level, almost-empty and a sticky underflow error to the read client.

## Interface
- ADDR_WIDTH, 3, RAM address width; pointers are ADDR_WIDTH+1 bits (extra wrap bit); depth 2^ADDR_WIDTH.
- AEMPTY_THRESH, 1, almost-empty asserts when level <= this value; legal range 0..2^ADDR_WIDTH.
- rclk  in  1  read clock; all state on rising edge.
- rrst_n  in  1  reset; synchronous, active-low.
- rinc  in  1  read request.
- rq2_wptr  in  ADDR_WIDTH+1  Gray write pointer, already two-flop synchronized into rclk.
- raddr  out  ADDR_WIDTH  binary read address to RAM, rbin[ADDR_WIDTH-1:0].
- rptr  out  ADDR_WIDTH+1  registered Gray read pointer, to write-domain synchronizer.
- rempty  out  1  registered empty flag.
- raempty  out  1  registered almost-empty flag.
- rlevel  out  ADDR_WIDTH+1  registered fill level as seen from read side, 0..2^ADDR_WIDTH.
- runderflow  out  1  sticky: read requested while empty.

## Operation
- Accepted read: rd_ok = rinc & ~rempty.
- rbinnext = rbin + rd_ok, modulo 2^(ADDR_WIDTH+1); wraps naturally, wrap bit toggles each full lap.
- rgraynext = (rbinnext >> 1) ^ rbinnext.
- rempty_val = (rgraynext == rq2_wptr): all bits equal, including the wrap bit.
- wbin_s = Gray-to-binary of rq2_wptr; level_next = wbin_s - rbinnext, modulo 2^(ADDR_WIDTH+1).
- Registered each cycle: rbin<=rbinnext, rptr<=rgraynext, rempty<=rempty_val, rlevel<=level_next, raempty<=(level_next <= AEMPTY_THRESH).
- Underflow: rinc & rempty sets runderflow; only reset clears it. The pointer does not move, and raddr is unchanged.
- Simultaneous read of the last entry and a new write visible on rq2_wptr: the flag is computed from rgraynext against the current rq2_wptr, so rempty follows the fresh comparison. There is no special case.
- Empty is pessimistic. It may stay high for synchronizer latency after a write, but it never deasserts while the FIFO is empty.

## Timing
- Reset (rrst_n low at rising edge): rbin=0, rptr=0, raddr=0, rempty=1, raempty=1, rlevel=0, runderflow=0. Reset mid-operation discards the pointer immediately on that edge.
- Latency: one rclk from an rinc or rq2_wptr change to the updated raddr/rptr/rempty/rlevel/raempty/runderflow.
- rinc is sampled every cycle; there is no handshake beyond rempty. The client reads RAM at raddr in the cycle it asserts rinc with rempty=0.
- After the last entry is read, rempty rises on the same edge that advances rptr.

## Configuration
- RPTR_EMPTY_LEVEL_EN defined: Gray-to-binary conversion, rlevel and raempty are implemented as above.
- Not defined: no conversion logic; rlevel is tied to 0 and raempty is a copy of rempty. rempty, rptr, raddr and runderflow behave identically in both builds.

## Structure
- Shared package fifo_pkg: bin2gray and gray2bin functions and the default ADDR_WIDTH constant, also used by the write side.
- One sub-module: gray2bin, combinational and parameterized by width. It is instantiated only under RPTR_EMPTY_LEVEL_EN.

## Test plan
- Reset: hold rrst_n low 2 cycles with rinc=1 -> rempty=1, raempty=1, rptr=4'b0000, raddr=0, rlevel=0, runderflow=0.
- Two entries: rq2_wptr=4'b0011 (bin 2). Next cycle rlevel=2, rempty=0, raempty=0. Then rinc for 2 cycles -> raddr 1 then 2, rlevel 1 then 0, raempty=1 after first read, rempty=1 after second, rptr=4'b0011.
- Underflow: from empty, pulse rinc 1 cycle -> raddr, rptr unchanged; runderflow=1 next cycle and stays 1 across later valid reads until reset.
- Full and wrap: rq2_wptr=4'b1100 (bin 8) -> rlevel=8. Read 8 times -> raddr 1..7 then 0, rptr=4'b1100, rempty=1. Then rq2_wptr=4'b1101 (bin 9) -> rempty=0, rlevel=1.
- Mid-operation reset: rq2_wptr=4'b0110 (bin 4), read 3 entries, assert rrst_n low 1 cycle -> next edge rbin=0, rptr=0, rempty=1, runderflow=0.
- Macro off build: repeat the two-entry test -> rlevel stays 0, and raempty equals rempty every cycle.
